// File: rtl/score_display_scan.sv
// Three-digit common-anode seven-segment scanner for the BCD score.
// Scores arrive through a one-deep pending register and are committed only at frame boundaries.
module score_display_scan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [11:0] bcd,
    input  logic        bcd_valid,
    output logic        bcd_ready,
    input  logic        blank_lz,
    input  logic        blink,
    output logic [6:0]  seg_n,
    output logic [2:0]  dig_n,
    output logic        frame_done
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [2:0] DIG_OFF   = 3'b111;

    typedef enum logic [1:0] {
        SLOT_UNITS = 2'd0,
        SLOT_TENS  = 2'd1,
        SLOT_HUND  = 2'd2
    } slot_e;

    logic [PRE_W-1:0] pre_q, pre_d;
    slot_e            slot_q, slot_d;
    logic [11:0]      disp_q, disp_d;
    logic [11:0]      pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic [FRM_W-1:0] frame_q, frame_d;
    logic             phase_q, phase_d;
    logic [6:0]       seg_n_q, seg_n_d;
    logic [2:0]       dig_n_q, dig_n_d;

    logic       tick;
    logic       boundary;
    logic       xfer;
    logic [3:0] nibble;
    logic       slot_blank;

    // Active-low segment patterns {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it unassigned (no latches).
        pre_d       = pre_q;
        slot_d      = slot_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        frame_d     = frame_q;
        phase_d     = phase_q;
        nibble      = disp_q[3:0];
        slot_blank  = 1'b0;

        tick     = (pre_q == PRE_MAX);
        boundary = tick && (slot_q == SLOT_HUND);
        xfer     = bcd_valid && !pend_full_q;

        pre_d = tick ? '0 : pre_q + PRE_W'(1);

        if (tick) begin
            case (slot_q)
                SLOT_UNITS: slot_d = SLOT_TENS;
                SLOT_TENS:  slot_d = SLOT_HUND;
                default:    slot_d = SLOT_UNITS;
            endcase
        end

        // Commit and accept are exclusive: accepting needs an empty pend, committing a full one.
        if (boundary && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            pend_d      = bcd;
            pend_full_d = 1'b1;
        end

        if (!blink) begin
            frame_d = '0;
            phase_d = 1'b0;
        end else if (boundary) begin
            if (frame_q == FRM_MAX) begin
                frame_d = '0;
                phase_d = !phase_q;
            end else begin
                frame_d = frame_q + FRM_W'(1);
            end
        end

        case (slot_q)
            SLOT_UNITS: nibble = disp_q[3:0];
            SLOT_TENS: begin
                nibble     = disp_q[7:4];
                slot_blank = blank_lz && (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
            end
            default: begin
                nibble     = disp_q[11:8];
                slot_blank = blank_lz && (disp_q[11:8] == 4'd0);
            end
        endcase
        if (blink && phase_q) begin
            slot_blank = 1'b1;
        end

        if (slot_blank) begin
            seg_n_d = SEG_BLANK;
            dig_n_d = DIG_OFF;
        end else begin
            seg_n_d = seg_decode(nibble);
            case (slot_q)
                SLOT_UNITS: dig_n_d = 3'b110;
                SLOT_TENS:  dig_n_d = 3'b101;
                default:    dig_n_d = 3'b011;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pre_q       <= '0;
            slot_q      <= SLOT_UNITS;
            // NOTE: disp and pend are reset too: a reset must drop any in-flight score.
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            frame_q     <= '0;
            phase_q     <= 1'b0;
            seg_n_q     <= SEG_BLANK;
            dig_n_q     <= DIG_OFF;
        end else begin
            pre_q       <= pre_d;
            slot_q      <= slot_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            frame_q     <= frame_d;
            phase_q     <= phase_d;
            seg_n_q     <= seg_n_d;
            dig_n_q     <= dig_n_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign dig_n      = dig_n_q;
    assign bcd_ready  = !pend_full_q;
    assign frame_done = boundary;

endmodule

// File: tb/tb_score_display_scan.sv
// Directed bench for score_display_scan with REFRESH_DIV=4, BLINK_FRAMES=2.
// Outputs are sampled 1 time unit after each rising edge; one frame is 12 samples.
module tb_score_display_scan;

    logic        clock;
    logic        reset_n;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic        bcd_ready;
    logic        blank_lz;
    logic        blink;
    logic [6:0]  seg_n;
    logic [2:0]  dig_n;
    logic        frame_done;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [11:0] bcd;
        logic        blank_lz;
        logic [6:0]  seg_u, seg_t, seg_h;
        logic [2:0]  dig_u, dig_t, dig_h;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];
    vec_t v_zero, v_dark, v157, v200, v234;

    score_display_scan #(
        .REFRESH_DIV  (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bcd        (bcd),
        .bcd_valid  (bcd_valid),
        .bcd_ready  (bcd_ready),
        .blank_lz   (blank_lz),
        .blink      (blink),
        .seg_n      (seg_n),
        .dig_n      (dig_n),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input vec_t v, input int r);
        if (r < 4) return v.seg_u;
        if (r < 8) return v.seg_t;
        return v.seg_h;
    endfunction

    function automatic logic [2:0] exp_dig(input vec_t v, input int r);
        if (r < 4) return v.dig_u;
        if (r < 8) return v.dig_t;
        return v.dig_h;
    endfunction

    // Checks 12 aligned samples (units, tens, hundreds) and leaves the bench at the next frame start.
    task automatic check_frame(input vec_t v);
        for (int r = 0; r < 12; r++) begin
            check("dig_n", 12'(dig_n), 12'(exp_dig(v, r)));
            check("seg_n", 12'(seg_n), 12'(exp_seg(v, r)));
            check("frame_done", 12'(frame_done), 12'(r == 10));
            step();
        end
    endtask

    // Hand a score over, wait for the boundary that commits it, and stop at that new frame's start.
    task automatic load(input logic [11:0] value);
        int n;
        bcd       = value;
        bcd_valid = 1'b1;
        n = 0;
        while (!bcd_ready && n < 40) begin
            step();
            n++;
        end
        check("ready_wait", 12'(bcd_ready), 12'(1));
        step();
        bcd_valid = 1'b0;
        n = 0;
        while (!frame_done && n < 40) begin
            step();
            n++;
        end
        check("commit_wait", 12'(frame_done), 12'(1));
        step();
        step();
    endtask

    initial begin
        reset_n   = 1'b0;
        bcd       = '0;
        bcd_valid = 1'b0;
        blank_lz  = 1'b0;
        blink     = 1'b0;

        v_zero = '{12'h000, 1'b0, 7'h40, 7'h40, 7'h40, 3'b110, 3'b101, 3'b011};
        v_dark = '{12'h000, 1'b0, 7'h7F, 7'h7F, 7'h7F, 3'b111, 3'b111, 3'b111};
        v157   = '{12'h157, 1'b0, 7'h78, 7'h12, 7'h79, 3'b110, 3'b101, 3'b011};
        v200   = '{12'h200, 1'b0, 7'h40, 7'h40, 7'h24, 3'b110, 3'b101, 3'b011};
        v234   = '{12'h234, 1'b0, 7'h19, 7'h30, 7'h24, 3'b110, 3'b101, 3'b011};

        vecs[0]  = '{12'h007, 1'b1, 7'h78, 7'h7F, 7'h7F, 3'b110, 3'b111, 3'b111};
        vecs[1]  = '{12'h070, 1'b1, 7'h40, 7'h78, 7'h7F, 3'b110, 3'b101, 3'b111};
        vecs[2]  = '{12'h0A5, 1'b1, 7'h12, 7'h3F, 7'h7F, 3'b110, 3'b101, 3'b111};
        vecs[3]  = '{12'h0A5, 1'b0, 7'h12, 7'h3F, 7'h40, 3'b110, 3'b101, 3'b011};
        vecs[4]  = '{12'h000, 1'b1, 7'h40, 7'h7F, 7'h7F, 3'b110, 3'b111, 3'b111};
        vecs[5]  = '{12'h908, 1'b1, 7'h00, 7'h40, 7'h10, 3'b110, 3'b101, 3'b011};
        vecs[6]  = '{12'hFED, 1'b0, 7'h3F, 7'h3F, 7'h3F, 3'b110, 3'b101, 3'b011};
        vecs[7]  = '{12'h234, 1'b0, 7'h19, 7'h30, 7'h24, 3'b110, 3'b101, 3'b011};
        vecs[8]  = '{12'h806, 1'b0, 7'h02, 7'h40, 7'h00, 3'b110, 3'b101, 3'b011};
        vecs[9]  = '{12'h00B, 1'b1, 7'h3F, 7'h7F, 7'h7F, 3'b110, 3'b111, 3'b111};
        vecs[10] = '{12'h000, 1'b0, 7'h40, 7'h40, 7'h40, 3'b110, 3'b101, 3'b011};

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_dig_n", 12'(dig_n), 12'(3'b111));
            check("rst_seg_n", 12'(seg_n), 12'(7'h7F));
            check("rst_ready", 12'(bcd_ready), 12'(1));
            check("rst_frame_done", 12'(frame_done), 12'(0));
        end
        reset_n = 1'b1;
        step();
        check_frame(v_zero);
        check_frame(v_zero);

        // Transfer 157 mid-frame, then hold 200 valid under backpressure.
        for (int r = 0; r < 12; r++) begin
            check("hs_dig_n", 12'(dig_n), 12'(exp_dig(v_zero, r)));
            check("hs_seg_n", 12'(seg_n), 12'(exp_seg(v_zero, r)));
            check("hs_frame_done", 12'(frame_done), 12'(r == 10));
            check("hs_ready", 12'(bcd_ready), 12'(r <= 4 || r == 11));
            if (r == 4) begin
                bcd       = 12'h157;
                bcd_valid = 1'b1;
            end
            if (r == 5) begin
                bcd = 12'h200;
            end
            step();
        end
        bcd_valid = 1'b0;
        check("bp_ready_low", 12'(bcd_ready), 12'(0));
        check_frame(v157);
        check("bp_ready_high", 12'(bcd_ready), 12'(1));
        check_frame(v200);

        // Decode and leading-zero table.
        for (int i = 0; i < NVEC; i++) begin
            blank_lz = vecs[i].blank_lz;
            load(vecs[i].bcd);
            check_frame(vecs[i]);
        end

        // Blink: two lit frames, two dark frames, repeating.
        blank_lz = 1'b0;
        load(12'h234);
        blink = 1'b1;
        check_frame(v234);
        check_frame(v234);
        check_frame(v_dark);
        check_frame(v_dark);
        check_frame(v234);
        check_frame(v234);
        for (int r = 0; r < 12; r++) begin
            check("blink_drop_dig_n", 12'(dig_n), 12'(r <= 5 ? 3'b111 : exp_dig(v234, r)));
            check("blink_drop_seg_n", 12'(seg_n), 12'(r <= 5 ? 7'h7F : exp_seg(v234, r)));
            check("blink_drop_frame_done", 12'(frame_done), 12'(r == 10));
            if (r == 5) begin
                blink = 1'b0;
            end
            step();
        end

        // One-cycle reset while a score is pending and the tens slot is active.
        bcd       = 12'h555;
        bcd_valid = 1'b1;
        step();
        bcd_valid = 1'b0;
        step();
        step();
        step();
        check("mid_pending", 12'(bcd_ready), 12'(0));
        reset_n   = 1'b0;
        bcd       = 12'h999;
        bcd_valid = 1'b1;
        step();
        check("mid_rst_dig_n", 12'(dig_n), 12'(3'b111));
        check("mid_rst_seg_n", 12'(seg_n), 12'(7'h7F));
        check("mid_rst_ready", 12'(bcd_ready), 12'(1));
        check("mid_rst_frame_done", 12'(frame_done), 12'(0));
        reset_n   = 1'b1;
        bcd_valid = 1'b0;
        step();
        check("post_rst_ready", 12'(bcd_ready), 12'(1));
        check_frame(v_zero);
        check_frame(v_zero);
        check("post_rst_ready_end", 12'(bcd_ready), 12'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
